// File: rtl/imem_port_arbiter.sv
// Arbitrates the boot instruction memory read port between instruction fetch and a
// debug/loader port, with range/alignment checking and a registered one-cycle response.
module imem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter logic [31:0] ERR_WORD     = 32'hDEADBEEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0]  STARVE_MAX  = 4'(STARVE_LIMIT);
  localparam logic [32:0] LAST_OFFSET = 33'(MEM_BYTES - 1);
  localparam int          IF_PORT     = 0;
  localparam int          DBG_PORT    = 1;

  logic        if_eff;
  logic        dbg_wins;
  logic        if_gnt;
  logic        dbg_gnt;
  logic        any_gnt;
  logic        addr_err;
  logic [31:0] win_addr;
  logic [32:0] offset;
  logic [31:0] resp_data;
  logic [3:0]  starve_cnt_reg;
  logic [3:0]  starve_cnt_next;

  logic        gnt_vec    [2];
  logic        rvalid_reg [2];
  logic [31:0] rdata_reg  [2];
  logic        err_reg    [2];

  always_comb begin
    if_eff   = if_req_i & ~if_flush_i;
    // Debug takes the port when IF is idle/flushed or once it has waited long enough.
    dbg_wins = dbg_req_i & (~if_eff | (starve_cnt_reg == STARVE_MAX));
    dbg_gnt  = dbg_wins & ~rst_i;
    if_gnt   = if_eff & ~dbg_wins & ~rst_i;
    any_gnt  = if_gnt | dbg_gnt;
    win_addr = dbg_gnt ? dbg_addr_i : if_addr_i;

    // 33-bit subtract: a borrow into bit 32 marks an address below the window.
    offset    = {1'b0, win_addr} - {1'b0, BASE_ADDR};
    addr_err  = offset[32] | (offset > LAST_OFFSET) | (win_addr[1:0] != 2'b00);
    resp_data = addr_err ? ERR_WORD : mem_rdata_i;

    mem_addr_o = (any_gnt && !addr_err) ? offset[31:0] : 32'h0;

    starve_cnt_next = starve_cnt_reg;
    if (!dbg_req_i || dbg_gnt) begin
      starve_cnt_next = 4'h0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + 4'h1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_reg <= 4'h0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign gnt_vec[IF_PORT]  = if_gnt;
  assign gnt_vec[DBG_PORT] = dbg_gnt;

  // One response register per port; data/err only move when that port is granted.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= 32'h0;
          err_reg[gi]    <= 1'b0;
        end else begin
          rvalid_reg[gi] <= gnt_vec[gi];
          if (gnt_vec[gi]) begin
            rdata_reg[gi] <= resp_data;
            err_reg[gi]   <= addr_err;
          end
        end
      end
    end
  endgenerate

  assign if_gnt_o     = if_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign if_rvalid_o  = rvalid_reg[IF_PORT];
  assign if_rdata_o   = rdata_reg[IF_PORT];
  assign if_err_o     = err_reg[IF_PORT];
  assign dbg_rvalid_o = rvalid_reg[DBG_PORT];
  assign dbg_rdata_o  = rdata_reg[DBG_PORT];
  assign dbg_err_o    = err_reg[DBG_PORT];

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: tasks push expected responses at grant time,
// a monitor pops and compares them one cycle later.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_flush = 1'b0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = 32'h0;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic [32:0] if_q [$];
  logic [32:0] dbg_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  imem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [32:0] expect_resp(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'hBFC00000;
    if (a < 32'hBFC00000 || a > 32'hBFC00FFF || a[1:0] != 2'b00)
      return {1'b1, 32'hDEADBEEF};
    return {1'b0, mem[off[11:2]]};
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic dr, input logic [31:0] da);
    @(posedge clk); #2;
    if_req = ir; if_addr = ia; if_flush = fl; dbg_req = dr; dbg_addr = da;
  endtask

  // Response scoreboard: exactly-one-cycle latency, no spurious responses.
  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (if_rvalid) begin
      checks++;
      if (if_q.size() == 0) begin
        errors++; $display("FAIL if_unexpected: if_rvalid=1 rdata=%h required no response", if_rdata);
      end else begin
        e = if_q.pop_front();
        if ({if_err, if_rdata} !== e) begin
          errors++; $display("FAIL if_resp: err/rdata=%b/%h required %b/%h", if_err, if_rdata, e[32], e[31:0]);
        end
      end
    end else if (if_q.size() != 0) begin
      checks++; errors++;
      e = if_q.pop_front();
      $display("FAIL if_missing: if_rvalid=0 required 1 (rdata %h)", e[31:0]);
    end
    if (dbg_rvalid) begin
      checks++;
      if (dbg_q.size() == 0) begin
        errors++; $display("FAIL dbg_unexpected: dbg_rvalid=1 rdata=%h required no response", dbg_rdata);
      end else begin
        e = dbg_q.pop_front();
        if ({dbg_err, dbg_rdata} !== e) begin
          errors++; $display("FAIL dbg_resp: err/rdata=%b/%h required %b/%h", dbg_err, dbg_rdata, e[32], e[31:0]);
        end
      end
    end else if (dbg_q.size() != 0) begin
      checks++; errors++;
      e = dbg_q.pop_front();
      $display("FAIL dbg_missing: dbg_rvalid=0 required 1 (rdata %h)", e[31:0]);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'hBFC00000, 1'b0, 1'b1, 32'hBFC00004);
    @(negedge clk);
    checks++;
    if ({if_gnt, dbg_gnt} !== 2'b00 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_gnt: gnt=%b mem_addr=%h required 00/0", {if_gnt, dbg_gnt}, mem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_rvalid, if_err, dbg_rvalid, dbg_err} !== 4'b0 || if_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outs: v/e=%b rdata=%h/%h required 0", {if_rvalid, if_err, dbg_rvalid, dbg_err}, if_rdata, dbg_rdata);
    end
    @(posedge clk); #2;
    rst = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hBFC00000 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_addr !== 32'(4 * i)) begin
        errors++; $display("FAIL b2b_%0d: if_gnt=%b dbg_gnt=%b mem_addr=%h required 1/0/%h", i, if_gnt, dbg_gnt, mem_addr, 32'(4 * i));
      end
      if_q.push_back(expect_resp(if_addr));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_addr_errors();
    logic [31:0] bad [3];
    bad[0] = 32'hBFC01000; bad[1] = 32'hBFBFFFFC; bad[2] = 32'hBFC00002;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bad[i], 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (if_gnt !== 1'b1 || mem_addr !== 32'h0) begin
        errors++; $display("FAIL addr_err_%0d: if_gnt=%b mem_addr=%h required 1/0", i, if_gnt, mem_addr);
      end
      if_q.push_back(expect_resp(bad[i]));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int  st = 0;
    logic exp_dbg;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'hBFC00020, 1'b0, 1'b1, 32'hBFC00010);
      @(negedge clk);
      exp_dbg = (st == 4);
      checks++;
      if (if_gnt !== !exp_dbg || dbg_gnt !== exp_dbg) begin
        errors++; $display("FAIL starve_%0d: if_gnt=%b dbg_gnt=%b required %b/%b", k, if_gnt, dbg_gnt, !exp_dbg, exp_dbg);
      end
      checks++;
      if (mem_addr !== (exp_dbg ? 32'h10 : 32'h20)) begin
        errors++; $display("FAIL starve_addr_%0d: mem_addr=%h required %h", k, mem_addr, exp_dbg ? 32'h10 : 32'h20);
      end
      if (exp_dbg) begin
        dbg_q.push_back(expect_resp(32'hBFC00010));
        st = 0;
      end else begin
        if_q.push_back(expect_resp(32'hBFC00020));
        st = (st == 4) ? 4 : st + 1;
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hBFC00008, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL flush_block: if_gnt=%b mem_addr=%h required 0/0", if_gnt, mem_addr);
    end
    drive(1'b1, 32'hBFC00008, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 32'h8) begin
      errors++; $display("FAIL flush_release: if_gnt=%b mem_addr=%h required 1/8", if_gnt, mem_addr);
    end
    if_q.push_back(expect_resp(32'hBFC00008));
    drive(1'b1, 32'hBFC0000C, 1'b1, 1'b1, 32'hBFC00030);
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b0 || dbg_gnt !== 1'b1 || mem_addr !== 32'h30) begin
      errors++; $display("FAIL flush_dbg: if_gnt=%b dbg_gnt=%b mem_addr=%h required 0/1/30", if_gnt, dbg_gnt, mem_addr);
    end
    dbg_q.push_back(expect_resp(32'hBFC00030));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset_after_grant();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00040);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1) begin
      errors++; $display("FAIL rst_pre_gnt: dbg_gnt=%b required 1", dbg_gnt);
    end
    dbg_q.push_back(expect_resp(32'hBFC00040));
    @(posedge clk); #2;
    rst = 1'b1; dbg_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({if_rvalid, if_err, dbg_rvalid, dbg_err} !== 4'b0 || if_rdata !== 32'h0 ||
        dbg_rdata !== 32'h0 || mem_addr !== 32'h0 || {if_gnt, dbg_gnt} !== 2'b00) begin
      errors++; $display("FAIL rst_after_gnt: v/e=%b rdata=%h/%h mem_addr=%h required all 0",
                         {if_rvalid, if_err, dbg_rvalid, dbg_err}, if_rdata, dbg_rdata, mem_addr);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_dbg_top_word();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00FFC);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'hFFC) begin
      errors++; $display("FAIL dbg_top: dbg_gnt=%b if_gnt=%b mem_addr=%h required 1/0/ffc", dbg_gnt, if_gnt, mem_addr);
    end
    dbg_q.push_back(expect_resp(32'hBFC00FFC));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 + 32'(i * 3);
    test_reset();
    test_back_to_back();
    test_addr_errors();
    test_starvation();
    test_flush();
    test_reset_after_grant();
    test_dbg_top_word();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (if_q.size() != 0 || dbg_q.size() != 0) begin
      errors++; $display("FAIL drain: pending if=%0d dbg=%0d required 0/0", if_q.size(), dbg_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
